// File: rtl/fifo_out_arbiter.sv
// fifo_out_arbiter
//   Round-robin scheduler that shares one byte-serial output unit among
//   NUM_CH first-word-fall-through FIFOs. Each round grants one ready FIFO,
//   pops a single word from it and hands that word to the output unit using
//   the out_start/out_finish handshake. The next round starts only after the
//   output unit reports the byte as done.
//
//   Parameters
//     NUM_CH : number of FIFO requesters (2..8)
//     DW     : FIFO and output data width
//     CW     : width of the completed-byte counter
//
//   Ports
//     clk        in   system clock, everything on the rising edge
//     reset      in   synchronous, active-high, overrides everything
//     enable     in   0 = no new grants (a byte already in flight completes)
//     ch_mask    in   per-channel grant permission
//     fifo_busy  in   per-FIFO busy flag
//     fifo_empty in   per-FIFO empty flag
//     fifo_data  in   per-FIFO head word, channel i at [i*DW +: DW]
//     fifo_re    out  one-cycle one-hot pop strobe to the granted FIFO
//     out_data   out  word presented to the output unit
//     out_start  out  start request to the output unit
//     out_finish in   output unit idle/done (1 = idle)
//     grant_ch   out  channel most recently granted
//     busy       out  high while a byte is in flight
//     sent_count out  bytes completed since reset, wraps silently
module fifo_out_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [NUM_CH-1:0]    fifo_busy,
    input  logic [NUM_CH-1:0]    fifo_empty,
    input  logic [NUM_CH*DW-1:0] fifo_data,
    output logic [NUM_CH-1:0]    fifo_re,
    output logic [DW-1:0]        out_data,
    output logic                 out_start,
    input  logic                 out_finish,
    output logic [2:0]           grant_ch,
    output logic                 busy,
    output logic [CW-1:0]        sent_count
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [NUM_CH-1:0]   ready;
    logic [NUM_CH-1:0]   fifo_re_n;
    logic [DW-1:0]       out_data_n;
    logic                out_start_n;
    logic [2:0]          grant_n;
    logic [CW-1:0]       count_n;
    logic [DW-1:0]       words [NUM_CH];
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       cand;

    assign ready = ch_mask & ~fifo_busy & ~fifo_empty;
    assign busy  = (state != ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_words
        assign words[g] = fifo_data[g*DW +: DW];
    end

    // Round-robin search: start one past the last grant and take the first
    // ready channel, wrapping modulo NUM_CH. The last granted channel is
    // visited last, so it only wins again when nobody else is ready.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IW'((int'(grant_ch) + k) % NUM_CH);
            if (!pick_valid && ready[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered, so every
    // output has a "next" copy that defaults to holding its current value;
    // fifo_re defaults to zero so the pop strobe is exactly one cycle wide.
    always_comb begin
        state_n     = state;
        fifo_re_n   = '0;
        out_start_n = out_start;
        out_data_n  = out_data;
        grant_n     = grant_ch;
        count_n     = sent_count;
        case (state)
            ST_IDLE: begin
                if (enable && out_finish && pick_valid) begin
                    grant_n             = 3'(pick_idx);
                    fifo_re_n[pick_idx] = 1'b1;
                    out_data_n          = words[pick_idx];
                    state_n             = ST_READ;
                end
            end
            ST_READ: begin
                out_start_n = 1'b1;
                state_n     = ST_START;
            end
            ST_START: begin
                // out_finish dropping is the output unit's acceptance.
                if (!out_finish) begin
                    out_start_n = 1'b0;
                    state_n     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (out_finish) begin
                    count_n = sent_count + CW'(1);
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset leaves grant_ch pointing at the last
    // channel so channel 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            fifo_re    <= '0;
            out_start  <= 1'b0;
            out_data   <= '0;
            grant_ch   <= 3'(NUM_CH - 1);
            sent_count <= '0;
        end else begin
            state      <= state_n;
            fifo_re    <= fifo_re_n;
            out_start  <= out_start_n;
            out_data   <= out_data_n;
            grant_ch   <= grant_n;
            sent_count <= count_n;
        end
    end

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// tb_fifo_out_arbiter
//   Self-checking bench for fifo_out_arbiter. Two instances share all inputs:
//   the default one (CW=16) and a narrow-counter one (CW=4) for wraparound.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge after each rising edge. Directed scenarios are followed by a long
//   randomized run compared against a transaction-level reference model.
module tb_fifo_out_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    fifo_busy;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH*DW-1:0] fifo_data;
    logic              out_finish;
    logic [NCH-1:0]    fifo_re;
    logic [NCH-1:0]    fifo_re4;
    logic [DW-1:0]     out_data;
    logic [DW-1:0]     out_data4;
    logic              out_start;
    logic              out_start4;
    logic [2:0]        grant_ch;
    logic [2:0]        grant4;
    logic              busy;
    logic              busy4;
    logic [CW-1:0]     sent_count;
    logic [3:0]        sent_count4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fifo_out_arbiter #(.NUM_CH(NCH), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .fifo_busy(fifo_busy), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_re(fifo_re), .out_data(out_data), .out_start(out_start),
        .out_finish(out_finish), .grant_ch(grant_ch), .busy(busy),
        .sent_count(sent_count)
    );

    fifo_out_arbiter #(.NUM_CH(NCH), .DW(DW), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .fifo_busy(fifo_busy), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_re(fifo_re4), .out_data(out_data4), .out_start(out_start4),
        .out_finish(out_finish), .grant_ch(grant4), .busy(busy4),
        .sent_count(sent_count4)
    );

    // Round-robin rule: first ready channel after 'last', wrapping around.
    function automatic int rr_pick(input logic [NCH-1:0] r, input logic [2:0] last);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (int'(last) + k) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enable     = 1'b1;
        ch_mask    = '1;
        fifo_busy  = '0;
        fifo_empty = '1;
        fifo_data  = 32'h44332211;
        out_finish = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until a pop strobe appears; steps = cycles taken, 0 on timeout.
    task automatic wait_grant(output int steps);
        steps = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (fifo_re != '0) begin
                steps = i;
                break;
            end
        end
    endtask

    // Plays the output unit for one byte, starting right after the pop
    // strobe was seen; returns once the arbiter is idle again.
    task automatic serve_byte(output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        do begin
            step();
            n++;
        end while (!out_start && n < 10);
        if (!out_start) ok = 1'b0;
        out_finish = 1'b0;
        step();
        out_finish = 1'b1;
        step();
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        if (busy) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        idle_inputs();
        fifo_empty = '0;
        step();
        step();
        tests_run++;
        if ({fifo_re, out_start, busy} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes got re=%b start=%b busy=%b expected all 0", fifo_re, out_start, busy);
        end
        tests_run++;
        if (grant_ch !== 3'd3 || out_data !== 8'h00 || sent_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs got grant=%0d data=%h count=%0d expected 3/00/0", grant_ch, out_data, sent_count);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_byte();
        do_reset();
        fifo_empty = 4'b1110;
        fifo_data  = 32'h000000A5;
        step();
        tests_run++;
        if (fifo_re !== 4'b0001 || out_data !== 8'hA5 || busy !== 1'b1 || grant_ch !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_grant got re=%b data=%h busy=%b grant=%0d expected 0001/a5/1/0", fifo_re, out_data, busy, grant_ch);
        end
        fifo_empty = 4'b1111;
        step();
        tests_run++;
        if (fifo_re !== 4'b0000 || out_start !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_start got re=%b start=%b expected 0000/1", fifo_re, out_start);
        end
        step();
        tests_run++;
        if (out_start !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_start_hold got start=%b expected 1", out_start);
        end
        out_finish = 1'b0;
        step();
        tests_run++;
        if (out_start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_accept got start=%b busy=%b expected 0/1", out_start, busy);
        end
        step();
        tests_run++;
        if (sent_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_wait_count got %0d expected 0", sent_count);
        end
        out_finish = 1'b1;
        step();
        tests_run++;
        if (sent_count !== 16'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_done got count=%0d busy=%b expected 1/1", sent_count, busy);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || fifo_re !== 4'b0000 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_idle got busy=%b re=%b data=%h expected 0/0000/a5", busy, fifo_re, out_data);
        end
    endtask

    task automatic test_all_ready();
        do_reset();
        fifo_empty = '0;
        for (int r = 0; r < 8; r++) begin
            int  expch;
            int  steps;
            bit  ok;
            expch = r % NCH;
            wait_grant(steps);
            tests_run++;
            if (steps != 1 || fifo_re !== NCH'(1 << expch) || out_data !== DW'((expch + 1) * 17)) begin
                tests_failed++;
                $display("[TB] FAIL all_ready_order r=%0d got re=%b data=%h after %0d cycles expected re=%b data=%h after 1",
                         r, fifo_re, out_data, steps, NCH'(1 << expch), DW'((expch + 1) * 17));
            end
            serve_byte(ok);
            tests_run++;
            if (!ok || sent_count !== CW'(r + 1)) begin
                tests_failed++;
                $display("[TB] FAIL all_ready_count r=%0d got ok=%b count=%0d expected 1/%0d", r, ok, sent_count, r + 1);
            end
        end
    endtask

    task automatic test_masked();
        int seq [4] = '{0, 3, 0, 3};
        do_reset();
        fifo_empty = '0;
        fifo_busy  = 4'b0010;
        ch_mask    = 4'b1011;
        for (int r = 0; r < 4; r++) begin
            int steps;
            bit ok;
            wait_grant(steps);
            tests_run++;
            if (steps == 0 || fifo_re !== NCH'(1 << seq[r]) || grant_ch !== 3'(seq[r])) begin
                tests_failed++;
                $display("[TB] FAIL masked_order r=%0d got re=%b grant=%0d expected re=%b grant=%0d",
                         r, fifo_re, grant_ch, NCH'(1 << seq[r]), seq[r]);
            end
            serve_byte(ok);
        end
    endtask

    task automatic test_finish_low();
        int steps;
        bit ok;
        do_reset();
        fifo_empty = '0;
        out_finish = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (fifo_re !== 4'b0000 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL finish_low_hold cycle %0d got re=%b busy=%b expected 0000/0", i, fifo_re, busy);
            end
        end
        out_finish = 1'b1;
        wait_grant(steps);
        tests_run++;
        if (steps != 1 || fifo_re !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL finish_low_release got re=%b after %0d cycles expected 0001 after 1", fifo_re, steps);
        end
        serve_byte(ok);
    endtask

    task automatic test_reset_mid();
        int steps;
        do_reset();
        fifo_empty = 4'b1011;
        wait_grant(steps);
        tests_run++;
        if (steps != 1 || fifo_re !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_grant got re=%b expected 0100", fifo_re);
        end
        step();
        out_finish = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (out_start !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd0 || grant_ch !== 3'd3 || fifo_re !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset got start=%b busy=%b count=%0d grant=%0d re=%b expected 0/0/0/3/0000",
                     out_start, busy, sent_count, grant_ch, fifo_re);
        end
        reset      = 1'b0;
        out_finish = 1'b1;
        fifo_empty = '1;
    endtask

    task automatic test_enable_drop();
        int steps;
        bit ok;
        do_reset();
        fifo_empty = 4'b1101;
        wait_grant(steps);
        tests_run++;
        if (steps != 1 || fifo_re !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL enable_grant got re=%b expected 0010", fifo_re);
        end
        enable = 1'b0;
        serve_byte(ok);
        tests_run++;
        if (!ok || sent_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL enable_complete got ok=%b count=%0d expected 1/1", ok, sent_count);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (fifo_re !== 4'b0000 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL enable_hold cycle %0d got re=%b busy=%b expected 0000/0", i, fifo_re, busy);
            end
        end
        enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_grant(steps);
            tests_run++;
            if (steps != 1 || fifo_re !== 4'b0010) begin
                tests_failed++;
                $display("[TB] FAIL single_channel_repeat r=%0d got re=%b after %0d cycles expected 0010 after 1", r, fifo_re, steps);
            end
            serve_byte(ok);
        end
    endtask

    task automatic test_wrap();
        int steps;
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        fifo_empty = '0;
        for (int r = 0; r < 17; r++) begin
            wait_grant(steps);
            if (steps == 0) all_ok = 1'b0;
            serve_byte(ok);
            if (!ok) all_ok = 1'b0;
        end
        tests_run++;
        if (!all_ok || sent_count !== 16'd17 || sent_count4 !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL wrap got ok=%b count=%0d count4=%0d expected 1/17/1", all_ok, sent_count, sent_count4);
        end
    endtask

    // Transaction-level reference: a grant happens on an edge where the model
    // is free and enable, out_finish and some ready channel are all present.
    // From the grant edge (age 0) the byte follows the handshake the bench
    // itself plays: start accepted D cycles late, finish low for L cycles,
    // the count bumps on the edge finish returns (age T), one done cycle
    // follows and the arbiter is free again on edge T+2.
    task automatic test_random();
        logic [2:0]     m_grant;
        int             m_count;
        bit             in_tx;
        int             age;
        int             dly;
        int             low;
        int             t_end;
        int             tx_ch;
        logic [DW-1:0]  m_data;
        logic [NCH-1:0] rdy;
        logic [NCH-1:0] exp_re;
        logic           exp_start;
        logic           exp_busy;
        do_reset();
        m_grant = 3'd3;
        m_count = 0;
        in_tx   = 1'b0;
        age     = 0;
        dly     = 0;
        low     = 1;
        t_end   = 0;
        tx_ch   = 0;
        m_data  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            enable     = ($urandom_range(0, 9) != 0);
            ch_mask    = NCH'($urandom);
            fifo_busy  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            fifo_empty = NCH'($urandom) & NCH'($urandom);
            fifo_data  = $urandom;
            if (in_tx) out_finish = !(age >= 1 + dly && age <= dly + low);
            else       out_finish = ($urandom_range(0, 7) != 0);
            step();
            if (in_tx) begin
                age++;
                if (age == t_end) m_count++;
                if (age == t_end + 2) in_tx = 1'b0;
            end
            if (!in_tx) begin
                rdy = ch_mask & ~fifo_busy & ~fifo_empty;
                if (enable && out_finish && rdy != '0) begin
                    tx_ch   = rr_pick(rdy, m_grant);
                    m_grant = 3'(tx_ch);
                    m_data  = fifo_data[tx_ch*DW +: DW];
                    in_tx   = 1'b1;
                    age     = 0;
                    dly     = $urandom_range(0, 2);
                    low     = $urandom_range(1, 3);
                    t_end   = 2 + dly + low;
                end
            end
            exp_re    = (in_tx && age == 0) ? NCH'(1 << tx_ch) : '0;
            exp_start = in_tx && age >= 1 && age <= 1 + dly;
            exp_busy  = in_tx && age <= t_end;
            tests_run++;
            if ({fifo_re, out_data, out_start, grant_ch, busy, sent_count} !==
                {exp_re, m_data, exp_start, m_grant, exp_busy, CW'(m_count)}) begin
                tests_failed++;
                $display("[TB] FAIL random cyc %0d got re=%b data=%h start=%b grant=%0d busy=%b count=%0d expected re=%b data=%h start=%b grant=%0d busy=%b count=%0d",
                         cyc, fifo_re, out_data, out_start, grant_ch, busy, sent_count,
                         exp_re, m_data, exp_start, m_grant, exp_busy, CW'(m_count));
            end
            tests_run++;
            if ({fifo_re4, out_data4, out_start4, grant4, busy4, sent_count4} !==
                {exp_re, m_data, exp_start, m_grant, exp_busy, 4'(m_count)}) begin
                tests_failed++;
                $display("[TB] FAIL random_cw4 cyc %0d got re=%b data=%h start=%b grant=%0d busy=%b count=%0d expected count=%0d",
                         cyc, fifo_re4, out_data4, out_start4, grant4, busy4, sent_count4, 4'(m_count));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_byte();
        test_all_ready();
        test_masked();
        test_finish_low();
        test_reset_mid();
        test_enable_drop();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
